// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32 definitions: opcodes, NOP encoding, hazard FSM
//               state encoding and operand-usage decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_WAIT  = 2'd1,
        ST_MDU_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } hz_state_e;

    // Only the U-type and JAL formats carry no rs1 field.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    endfunction

    // rs2 is a real operand only for R-type, stores and branches.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use detector. Compares the destination of
//               a load in EX against the source operands the ID instruction
//               actually reads. Reusable by forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] id_instr,
    input  logic [XLEN-1:0] ex_instr,
    output logic            lu_hit
);

    logic [4:0] w_ex_rd;
    logic [4:0] w_id_rs1;
    logic [4:0] w_id_rs2;
    logic [6:0] w_ex_op;
    logic [6:0] w_id_op;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_unused_bits;

    assign w_ex_op  = ex_instr[6:0];
    assign w_ex_rd  = ex_instr[11:7];
    assign w_id_op  = id_instr[6:0];
    assign w_id_rs1 = id_instr[19:15];
    assign w_id_rs2 = id_instr[24:20];

    // Immediate / funct fields do not take part in the compare.
    assign w_unused_bits = ^{id_instr, ex_instr};

    // Operand-qualified register compare; x0 is never a real dependency.
    always_comb begin
        w_rs1_hit = uses_rs1(w_id_op) && (w_id_rs1 == w_ex_rd);
        w_rs2_hit = uses_rs2(w_id_op) && (w_id_rs2 == w_ex_rd);
        lu_hit    = (w_ex_op == OPC_LOAD) && (w_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : 5-stage pipeline hazard controller. Load-use stall of
//               LU_STALL cycles, mul/div hold, taken-branch flush and a
//               saturating stall-cycle performance counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LU_STALL = 1,
    parameter int EN_MDU   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  id_instr,
    input  logic [XLEN-1:0]  ex_instr,
    input  logic             taken_branch,
    input  logic             mdu_busy,
    output logic [3:0]       stall,
    output logic [1:0]       bubble,
    output logic [1:0]       flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       hz_state
);

    localparam logic [2:0] C_LU_INIT = 3'(LU_STALL - 1);

    hz_state_e r_state;
    hz_state_e w_next_state;
    logic [2:0] r_lu_cnt;
    logic [2:0] w_next_lu_cnt;
    logic       w_lu_hit;
    logic       w_mdu_busy;

    hazard_detect #(
        .XLEN (XLEN)
    ) u_detect (
        .id_instr (id_instr),
        .ex_instr (ex_instr),
        .lu_hit   (w_lu_hit)
    );

    assign w_mdu_busy = (EN_MDU != 0) && mdu_busy;
    assign hz_state   = r_state;

    // State and load-use countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_lu_cnt <= 3'd0;
        end else begin
            r_state  <= w_next_state;
            r_lu_cnt <= w_next_lu_cnt;
        end
    end

    // Next-state and Mealy output decode; FLUSH reuses the RUN decisions.
    always_comb begin
        w_next_state  = r_state;
        w_next_lu_cnt = r_lu_cnt;
        stall         = 4'b0000;
        bubble        = 2'b00;
        flush         = 2'b00;
        case (r_state)
            ST_LU_WAIT: begin
                if (taken_branch) begin
                    flush         = 2'b11;
                    w_next_state  = ST_FLUSH;
                    w_next_lu_cnt = 3'd0;
                end else begin
                    stall         = 4'b0011;
                    bubble        = 2'b01;
                    w_next_lu_cnt = r_lu_cnt - 3'd1;
                    if (r_lu_cnt <= 3'd1) begin
                        w_next_state  = ST_RUN;
                        w_next_lu_cnt = 3'd0;
                    end
                end
            end
            ST_MDU_WAIT: begin
                // EX holds the MDU op, so a branch cannot be resolving here.
                if (w_mdu_busy) begin
                    stall  = 4'b0111;
                    bubble = 2'b10;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
                if (taken_branch) begin
                    flush        = 2'b11;
                    w_next_state = ST_FLUSH;
                end else if (w_mdu_busy) begin
                    stall        = 4'b0111;
                    bubble       = 2'b10;
                    w_next_state = ST_MDU_WAIT;
                end else if (w_lu_hit) begin
                    stall  = 4'b0011;
                    bubble = 2'b01;
                    if (LU_STALL > 1) begin
                        w_next_state  = ST_LU_WAIT;
                        w_next_lu_cnt = C_LU_INIT;
                    end
                end
            end
        endcase
    end

    // Saturating count of cycles with any hold enable asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if ((|stall) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl. Instance A: LU_STALL=1,
//               CNT_W=16. Instance B: LU_STALL=3, CNT_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [6:0] C_LOAD   = 7'b0000011;
    localparam logic [6:0] C_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP     = 7'b0110011;
    localparam logic [6:0] C_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_BRANCH = 7'b1100011;
    localparam logic [6:0] C_LUI    = 7'b0110111;
    localparam logic [31:0] C_NOP   = 32'h0000_0013;

    typedef struct {
        bit          sel;
        logic [25:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        a_rst = 1'b0, b_rst = 1'b0;
    logic [31:0] a_id = C_NOP, a_ex = C_NOP, b_id = C_NOP, b_ex = C_NOP;
    logic        a_br = 1'b0, a_mdu = 1'b0, b_br = 1'b0, b_mdu = 1'b0;
    logic [3:0]  a_stall, b_stall;
    logic [1:0]  a_bubble, b_bubble, a_flush, b_flush, a_state, b_state;
    logic [15:0] a_cnt;
    logic [2:0]  b_cnt;

    sb_entry_t sb_q[$];
    string     name_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.XLEN(32), .LU_STALL(1), .EN_MDU(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .id_instr(a_id), .ex_instr(a_ex),
        .taken_branch(a_br), .mdu_busy(a_mdu), .stall(a_stall),
        .bubble(a_bubble), .flush(a_flush), .stall_cnt(a_cnt), .hz_state(a_state)
    );

    hazard_ctrl #(.XLEN(32), .LU_STALL(3), .EN_MDU(1), .CNT_W(3)) dut_b (
        .clk(clk), .rst(b_rst), .id_instr(b_id), .ex_instr(b_ex),
        .taken_branch(b_br), .mdu_busy(b_mdu), .stall(b_stall),
        .bubble(b_bubble), .flush(b_flush), .stall_cnt(b_cnt), .hz_state(b_state)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), op};
    endfunction

    function automatic logic [25:0] ex(input logic [3:0] s, input logic [1:0] b,
                                       input logic [1:0] f, input logic [1:0] st, input int cnt);
        return {s, b, f, st, 16'(cnt)};
    endfunction

    // One stimulus cycle: drive the selected instance, park the other, queue expectation.
    task automatic apply(input bit sel, input logic r, input logic [31:0] id, input logic [31:0] exi,
                         input logic br, input logic mdu, input logic [25:0] e, input string nm);
        sb_entry_t ent;
        @(posedge clk);
        #1;
        if (!sel) begin
            a_rst = r; a_id = id; a_ex = exi; a_br = br; a_mdu = mdu;
            b_id = C_NOP; b_ex = C_NOP; b_br = 1'b0; b_mdu = 1'b0;
        end else begin
            b_rst = r; b_id = id; b_ex = exi; b_br = br; b_mdu = mdu;
            a_id = C_NOP; a_ex = C_NOP; a_br = 1'b0; a_mdu = 1'b0;
        end
        ent.sel = sel;
        ent.exp = e;
        sb_q.push_back(ent);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are Mealy, so sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t   e;
            string       nm;
            logic [25:0] act;
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            act = e.sel ? {b_stall, b_bubble, b_flush, b_state, 13'b0, b_cnt}
                        : {a_stall, a_bubble, a_flush, a_state, a_cnt};
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got stall=%b bubble=%b flush=%b state=%0d cnt=%0d, expected stall=%b bubble=%b flush=%b state=%0d cnt=%0d",
                         nm, act[25:22], act[21:20], act[19:18], act[17:16], act[15:0],
                         e.exp[25:22], e.exp[21:20], e.exp[19:18], e.exp[17:16], e.exp[15:0]);
            end
        end
    end

    initial begin
        logic [31:0] lw5, add_dep, lw7, sw_dep, mul;
        lw5     = mk(C_LOAD, 5, 1, 0);
        add_dep = mk(C_OP, 6, 5, 1);
        lw7     = mk(C_LOAD, 7, 3, 0);
        sw_dep  = mk(C_STORE, 0, 2, 7);
        mul     = mk(C_OP, 9, 1, 2);

        // ---------------- instance A: LU_STALL=1 ----------------
        apply(0, 0, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 0), "a_reset");
        apply(0, 1, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 0), "a_idle");
        apply(0, 1, add_dep, lw5, 0, 0, ex(4'b0011, 2'b01, 2'b00, 0, 0), "a_lu_rs1");
        apply(0, 1, add_dep, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 1), "a_lu_release");
        apply(0, 1, mk(C_OP, 1, 0, 0), mk(C_LOAD, 0, 1, 0), 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 1), "a_x0_load");
        apply(0, 1, mk(C_LUI, 3, 3, 3), mk(C_LOAD, 3, 1, 0), 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 1), "a_lui_no_rs1");
        apply(0, 1, mk(C_OP_IMM, 1, 2, 4), mk(C_LOAD, 4, 1, 0), 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 1), "a_opimm_no_rs2");
        apply(0, 1, add_dep, lw5, 1, 0, ex(4'b0000, 2'b00, 2'b11, 0, 1), "a_branch_beats_lu");
        apply(0, 1, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 3, 1), "a_flush_state");
        apply(0, 1, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 1), "a_after_flush");
        apply(0, 1, add_dep, lw5, 0, 1, ex(4'b0111, 2'b10, 2'b00, 0, 1), "a_mdu_beats_lu");
        apply(0, 1, C_NOP, mul, 0, 1, ex(4'b0111, 2'b10, 2'b00, 2, 2), "a_mdu_wait2");
        apply(0, 1, C_NOP, mul, 1, 1, ex(4'b0111, 2'b10, 2'b00, 2, 3), "a_mdu_ignore_br");
        apply(0, 1, C_NOP, mul, 0, 1, ex(4'b0111, 2'b10, 2'b00, 2, 4), "a_mdu_wait4");
        apply(0, 1, C_NOP, mul, 0, 0, ex(4'b0000, 2'b00, 2'b00, 2, 5), "a_mdu_done");
        apply(0, 1, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 5), "a_mdu_run");

        // ---------------- instance B: LU_STALL=3, CNT_W=3 ----------------
        apply(1, 0, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 0), "b_reset");
        apply(1, 1, sw_dep, lw7, 0, 0, ex(4'b0011, 2'b01, 2'b00, 0, 0), "b_lu_rs2_c1");
        apply(1, 1, sw_dep, C_NOP, 0, 0, ex(4'b0011, 2'b01, 2'b00, 1, 1), "b_lu_rs2_c2");
        apply(1, 1, sw_dep, C_NOP, 0, 0, ex(4'b0011, 2'b01, 2'b00, 1, 2), "b_lu_rs2_c3");
        apply(1, 1, sw_dep, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 3), "b_lu_rs2_run");
        apply(1, 1, sw_dep, lw7, 0, 0, ex(4'b0011, 2'b01, 2'b00, 0, 3), "b_lu_again");
        apply(1, 1, sw_dep, mk(C_BRANCH, 0, 1, 2), 1, 0, ex(4'b0000, 2'b00, 2'b11, 1, 4), "b_lu_branch_abort");
        apply(1, 1, sw_dep, lw7, 0, 0, ex(4'b0011, 2'b01, 2'b00, 3, 4), "b_lu_in_flush");
        apply(1, 1, sw_dep, C_NOP, 0, 0, ex(4'b0011, 2'b01, 2'b00, 1, 5), "b_lu_wait_after_flush");
        apply(1, 0, sw_dep, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 0), "b_reset_mid_stall");
        for (int k = 1; k <= 10; k++) begin
            apply(1, 1, C_NOP, mul, 0, 1,
                  ex(4'b0111, 2'b10, 2'b00, (k == 1) ? 0 : 2, (k - 1 > 7) ? 7 : k - 1), "b_sat_hold");
        end
        apply(1, 1, C_NOP, mul, 0, 0, ex(4'b0000, 2'b00, 2'b00, 2, 7), "b_sat_release");
        apply(1, 1, C_NOP, C_NOP, 0, 0, ex(4'b0000, 2'b00, 2'b00, 0, 7), "b_sat_hold_max");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage RV32 core, and the successor to the single-cycle load-use halt logic. It sits beside the IF/ID/EX/MEM/WB pipeline registers. It detects load-use hazards with precise source-operand usage, holds for a configurable number of load stall cycles, holds for a multi-cycle mul/div unit, and flushes on taken branches. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- XLEN, 32, instruction/data width (instruction fields taken from bits [31:0])
- LU_STALL, 1, load-use stall length in cycles, legal 1..7
- EN_MDU, 1, 1 = honour mdu_busy; 0 = mdu_busy ignored
- CNT_W, 16, width of the stall_cnt performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_instr  in  XLEN  instruction in the ID stage
- ex_instr  in  XLEN  instruction in the EX stage
- taken_branch  in  1  branch/jump resolved taken in EX this cycle
- mdu_busy  in  1  mul/div in EX still computing
- stall  out  4  hold enables {mem,ex,id,if}; 1 = the pipeline register feeding that stage keeps its value
- bubble  out  2  {ex_mem, id_ex}; 1 = load a NOP (0x00000013) into that register
- flush  out  2  {id_ex, if_id}; 1 = load a NOP into that register
- stall_cnt  out  CNT_W  cycles with any stall bit set, saturating
- hz_state  out  2  current FSM state, for debug

## Operation
- **Load-use hazard (lu_hit).** Asserted when all of the following hold:
  - ex_instr[6:0] == LOAD;
  - ex rd != 0;
  - ID uses rs1 and rs1 == ex rd, or ID uses rs2 and rs2 == ex rd.
- **rs1 usage.** rs1 is used by every opcode except LUI, AUIPC and JAL.
- **rs2 usage.** rs2 is used only by OP, STORE and BRANCH.
- **FSM states.** RUN, LU_WAIT, MDU_WAIT, FLUSH.
- **From RUN.** Priority order, first match wins:
  - taken_branch: go to FLUSH; flush=2'b11 in this cycle.
  - EN_MDU && mdu_busy: go to MDU_WAIT; stall=4'b0111, bubble=2'b10.
  - lu_hit: stall=4'b0011, bubble=2'b01 in this cycle. Go to LU_WAIT with lu_cnt=LU_STALL-1 if LU_STALL>1; otherwise stay in RUN.
  - otherwise: all outputs 0.
- **LU_WAIT.**
  - Holds stall=4'b0011, bubble=2'b01.
  - lu_cnt decrements each cycle; return to RUN when lu_cnt==1 at a clock edge.
  - taken_branch in LU_WAIT (an older branch in EX) aborts the wait: go to FLUSH, flush=2'b11.
- **MDU_WAIT.**
  - stall=4'b0111, bubble=2'b10 while mdu_busy.
  - When mdu_busy falls, outputs are 0 in that cycle and the FSM returns to RUN.
  - taken_branch is ignored here, because EX is occupied by the MDU op.
- **FLUSH.**
  - One cycle with all outputs 0; next state RUN.
  - The flush itself is asserted in the cycle taken_branch is seen, not in FLUSH.
  - A hazard detected in FLUSH is evaluated as in RUN.
- **stall_cnt.** Increments on every clock where |stall is 1. It holds at 2^CNT_W-1.

## Timing
- All outputs are Mealy: combinational from the registered state/lu_cnt and the current inputs, valid in the same cycle as the hazard.
- **Reset.** State RUN, lu_cnt 0, stall_cnt 0, therefore stall=0, bubble=0, flush=0, hz_state=0. A reset mid-stall aborts immediately.
- **Load-use latency.** Exactly LU_STALL stalled cycles per load-use instance. The dependent instruction reaches EX LU_STALL+1 cycles after the load.
- **Branch.** Flush acts on the clock edge ending the cycle in which taken_branch is seen. Two wrong-path instructions are discarded.
- **Simultaneous events.** taken_branch beats mdu_busy, which beats lu_hit, in RUN and FLUSH only.
- **x0 destination.** A load to x0 never stalls.

## Structure
- **Shared package riscv_pkg.**
  - Opcode constants: LOAD, STORE, OP, OP_IMM, BRANCH, LUI, AUIPC, JAL, JALR.
  - NOP encoding.
  - hz_state encoding: RUN=0, LU_WAIT=1, MDU_WAIT=2, FLUSH=3.
- **Sub-module hazard_detect.**
  - Purely combinational: operand-usage decode plus rd/rs compare, producing lu_hit.
  - Kept separate so forwarding logic can reuse it.
- **Top level.** Holds the FSM, lu_cnt and stall_cnt.

## Test plan
- **Load-use, rs1, LU_STALL=1.** EX=lw x5, ID=add x6,x5,x1 → stall=0011 and bubble=01 for 1 cycle; stall_cnt=1.
- **Load-use, rs2, LU_STALL=3.** EX=lw x7, ID=sw x7,0(x2) → 3 stall cycles with hz_state=1; RUN on the 4th cycle.
- **No false stalls.**
  - EX=lw x0, ID=add x1,x0,x0 → no stall.
  - EX=lw x3, ID=lui x3 → no stall.
- **Branch priority.** taken_branch with lu_hit in the same cycle → flush=11, stall=0000; FLUSH next; RUN after.
- **MDU hold.** EN_MDU=1, mdu_busy high 4 cycles → stall=0111 and bubble=10 for 4 cycles; outputs 0 in the cycle busy falls.
- **Reset and saturation.**
  - Assert rst during LU_WAIT → all outputs 0 immediately.
  - CNT_W=3 with 10 stall cycles → stall_cnt=7.
